agu_request_arbiter: RTL and testbench

- Shares one address_generation_unit (AGU) instance among NUM_REQ requesters (weight loader, activation loader, output writer, ...).
- Arbitrates whole jobs round-robin and latches the winner's configuration.
- Drives the AGU config/start handshake and forwards the AGU burst-address stream to the memory port, tagged with the owner ID.
- Returns a per-requester done pulse; sits between the tile loaders and the AXI burst master.

---
 rtl/garuda_agu_pkg.sv | 34 +++
 rtl/agu_request_arbiter_if.sv | 46 ++++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/agu_request_arbiter.sv | 117 +++++++++++
 tb/tb_agu_request_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/garuda_agu_pkg.sv
// Shared types for the AGU and its request arbiter.
// Job configuration layout, address-pattern codes and arbiter FSM states.
package garuda_agu_pkg;

    localparam int AGU_ADDR_W  = 32;
    localparam int AGU_COUNT_W = 16;

    typedef enum logic [2:0] {
        LINEAR  = 3'd0,
        STRIDED = 3'd1,
        BLOCKED = 3'd2
    } agu_pattern_e;

    typedef struct packed {
        logic [AGU_ADDR_W-1:0]  base;
        logic [AGU_ADDR_W-1:0]  stride;
        logic [AGU_COUNT_W-1:0] count;
        logic [AGU_ADDR_W-1:0]  elem_size;
        agu_pattern_e           pattern;
    } agu_cfg_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_RELEASE,
        ST_ZERO_DONE
    } agu_arb_state_e;

    function automatic logic is_empty_job(input agu_cfg_t cfg);
        return cfg.count == '0;
    endfunction

endpackage

// File: rtl/agu_request_arbiter_if.sv
// AGU-side and memory-side signals of the shared AGU arbiter.
// master = arbiter view, slave = AGU plus memory port view.
interface agu_request_arbiter_if
    import garuda_agu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_W       = 2
);
    logic                  agu_cfg_valid;
    logic                  agu_start;
    agu_cfg_t              agu_cfg;
    logic                  agu_cfg_ready;
    logic                  agu_done;

    logic                  agu_addr_valid;
    logic [ADDR_WIDTH-1:0] agu_addr;
    logic [7:0]            agu_burst_len;
    logic [2:0]            agu_burst_size;
    logic                  agu_last;
    logic                  agu_addr_ready;

    logic                  mem_addr_valid;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_burst_len;
    logic [2:0]            mem_burst_size;
    logic                  mem_last;
    logic [ID_W-1:0]       mem_id;
    logic                  mem_addr_ready;

    modport master (
        output agu_cfg_valid, agu_start, agu_cfg, agu_addr_ready,
        output mem_addr_valid, mem_addr, mem_burst_len,
        output mem_burst_size, mem_last, mem_id,
        input  agu_cfg_ready, agu_done, agu_addr_valid, agu_addr,
        input  agu_burst_len, agu_burst_size, agu_last, mem_addr_ready
    );

    modport slave (
        input  agu_cfg_valid, agu_start, agu_cfg, agu_addr_ready,
        input  mem_addr_valid, mem_addr, mem_burst_len,
        input  mem_burst_size, mem_last, mem_id,
        output agu_cfg_ready, agu_done, agu_addr_valid, agu_addr,
        output agu_burst_len, agu_burst_size, agu_last, mem_addr_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched circularly from a pointer.
// Pointer moves past the winner when accept_i is strobed.
module rr_arbiter #(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               accept_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [ID_W-1:0] ptr_q;

    always_comb begin
        int   j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_q) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= (int'(idx_o) == NUM_REQ - 1) ? '0 : idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/agu_request_arbiter.sv
// Shares one AGU among NUM_REQ requesters, one whole job at a time.
// Latches the winning config, launches the AGU and tags its address stream.
module agu_request_arbiter
    import garuda_agu_pkg::*;
#(
    parameter  int NUM_REQ    = 3,
    parameter  int ADDR_WIDTH = 32,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_valid_i,
    output logic [NUM_REQ-1:0]    req_ready_o,
    input  agu_cfg_t [NUM_REQ-1:0] req_cfg_i,
    output logic [NUM_REQ-1:0]    req_done_o,
    agu_request_arbiter_if.master bus,
    output logic                  busy_o,
    output logic [ID_W-1:0]       active_id_o
);

    agu_arb_state_e        state_q, state_d;
    logic [ID_W-1:0]       id_q;
    agu_cfg_t              cfg_q;
    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       win_idx;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] fwd_addr;

    assign accept = (state_q == ST_IDLE) && rst_ni && (|req_valid_i);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_valid_i),
        .accept_i (accept),
        .gnt_o    (gnt),
        .idx_o    (win_idx)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            cfg_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q  <= win_idx;
                cfg_q <= req_cfg_i[win_idx];
            end
        end
    end

    always_comb begin
        state_d            = state_q;
        req_ready_o        = '0;
        req_done_o         = '0;
        bus.agu_cfg_valid  = 1'b0;
        bus.agu_start      = 1'b0;
        bus.agu_addr_ready = 1'b0;
        bus.mem_addr_valid = 1'b0;
        bus.mem_burst_len  = '0;
        bus.mem_burst_size = '0;
        bus.mem_last       = 1'b0;
        bus.mem_id         = '0;
        fwd_addr           = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_o = gnt;
                    state_d = is_empty_job(req_cfg_i[win_idx]) ?
                              ST_ZERO_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                bus.agu_cfg_valid = 1'b1;
                bus.agu_start     = 1'b1;
                if (bus.agu_cfg_ready) state_d = ST_RUN;
            end
            ST_RUN: begin
                bus.mem_addr_valid = bus.agu_addr_valid;
                bus.agu_addr_ready = bus.mem_addr_ready;
                fwd_addr           = bus.agu_addr;
                bus.mem_burst_len  = bus.agu_burst_len;
                bus.mem_burst_size = bus.agu_burst_size;
                bus.mem_last       = bus.agu_last;
                bus.mem_id         = id_q;
                if (bus.agu_done) begin
                    req_done_o[id_q] = 1'b1;
                    state_d          = ST_RELEASE;
                end
            end
            // cfg_valid stays low here so the AGU can leave its DONE state
            ST_RELEASE: state_d = ST_IDLE;
            ST_ZERO_DONE: begin
                req_done_o[id_q] = 1'b1;
                state_d          = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.mem_addr = fwd_addr;
    assign bus.agu_cfg  = cfg_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign active_id_o  = id_q;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold
        a_valid_hold: assert property (
            @(posedge clk_i) disable iff (!rst_ni)
            req_valid_i[g] && !req_ready_o[g] |=> req_valid_i[g]
        );
    end

endmodule

// File: tb/tb_agu_request_arbiter.sv
// Bench for agu_request_arbiter: plays requesters, AGU and memory port,
// predicting grants with a round-robin model and addresses from the job cfg.
module tb_agu_request_arbiter;
    import garuda_agu_pkg::*;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int IW = 2;

    logic            clk_i  = 1'b0;
    logic            rst_ni = 1'b0;
    logic [N-1:0]    req_valid_i;
    logic [N-1:0]    req_ready_o;
    agu_cfg_t [N-1:0] req_cfg_i;
    logic [N-1:0]    req_done_o;
    logic            busy_o;
    logic [IW-1:0]   active_id_o;

    agu_request_arbiter_if #(.ADDR_WIDTH(AW), .ID_W(IW)) bus ();

    agu_request_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_cfg_i   (req_cfg_i),
        .req_done_o  (req_done_o),
        .bus         (bus),
        .busy_o      (busy_o),
        .active_id_o (active_id_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int rr_ptr = 0;

    task automatic idle_inputs();
        bus.agu_cfg_ready  = 1'b0;
        bus.agu_done       = 1'b0;
        bus.agu_addr_valid = 1'b0;
        bus.agu_addr       = '0;
        bus.agu_burst_len  = '0;
        bus.agu_burst_size = '0;
        bus.agu_last       = 1'b0;
        bus.mem_addr_ready = 1'b0;
    endtask

    function automatic agu_cfg_t rand_cfg(input bit zero);
        agu_cfg_t c;
        c.base      = $urandom & 32'hFFFF_FFF0;
        c.stride    = 32'(4 << $urandom_range(0, 3));
        c.count     = zero ? 16'd0 : 16'($urandom_range(1, 256));
        c.elem_size = 32'(1 << $urandom_range(0, 3));
        c.pattern   = agu_pattern_e'(3'($urandom_range(0, 2)));
        return c;
    endfunction

    // Reference: first pending requester at or after the pointer, circularly
    function automatic int pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_job(input int nbeats, input int cfg_stall,
                          input int mem_stall);
        int          w;
        int          seen;
        agu_cfg_t    c;
        logic [31:0] addr;
        logic [7:0]  blen;
        logic [2:0]  bsz;
        w = pick(req_valid_i);
        c = req_cfg_i[w];
        #1;
        checks++;
        if (req_ready_o !== N'(1 << w) || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL grant: ready=%b busy=%b want ready=%b busy=0",
                     req_ready_o, busy_o, N'(1 << w));
        end
        @(negedge clk_i);
        req_valid_i[w] = 1'b0;
        rr_ptr = (w + 1) % N;
        if (c.count == 16'd0) begin
            #1;
            checks++;
            if (req_done_o !== N'(1 << w) || bus.agu_cfg_valid !== 1'b0 ||
                busy_o !== 1'b1) begin
                errors++;
                $display("FAIL zero_done: done=%b cfg_valid=%b busy=%b want %b 0 1",
                         req_done_o, bus.agu_cfg_valid, busy_o, N'(1 << w));
            end
            @(negedge clk_i);
            return;
        end
        for (int s = 0; s < cfg_stall; s++) begin
            #1;
            checks++;
            if (bus.agu_cfg_valid !== 1'b1 || bus.agu_start !== 1'b1 ||
                bus.agu_cfg !== c || req_ready_o !== '0) begin
                errors++;
                $display("FAIL launch_hold: valid=%b start=%b cfg=%h ready=%b want 1 1 %h 0",
                         bus.agu_cfg_valid, bus.agu_start, bus.agu_cfg,
                         req_ready_o, c);
            end
            @(negedge clk_i);
        end
        bus.agu_cfg_ready = 1'b1;
        #1;
        checks++;
        if (bus.agu_cfg_valid !== 1'b1 || bus.agu_start !== 1'b1 ||
            bus.agu_cfg !== c) begin
            errors++;
            $display("FAIL launch_hs: valid=%b start=%b cfg=%h want 1 1 %h",
                     bus.agu_cfg_valid, bus.agu_start, bus.agu_cfg, c);
        end
        @(negedge clk_i);
        bus.agu_cfg_ready = 1'b0;
        seen = 0;
        for (int b = 0; b < nbeats; b++) begin
            addr = c.base + 32'(b) * c.stride;
            blen = 8'($urandom_range(0, 255));
            bsz  = 3'($urandom_range(0, 7));
            bus.agu_addr_valid = 1'b1;
            bus.agu_addr       = addr;
            bus.agu_burst_len  = blen;
            bus.agu_burst_size = bsz;
            bus.agu_last       = (b == nbeats - 1);
            for (int s = 0; s < ((b == 0) ? mem_stall : 0); s++) begin
                bus.mem_addr_ready = 1'b0;
                #1;
                checks++;
                if (bus.mem_addr_valid !== 1'b1 || bus.agu_addr_ready !== 1'b0 ||
                    bus.mem_addr !== addr || bus.mem_burst_len !== blen ||
                    bus.mem_burst_size !== bsz) begin
                    errors++;
                    $display("FAIL mem_stall: v=%b rdy=%b a=%h len=%h want 1 0 %h %h",
                             bus.mem_addr_valid, bus.agu_addr_ready,
                             bus.mem_addr, bus.mem_burst_len, addr, blen);
                end
                @(negedge clk_i);
            end
            bus.mem_addr_ready = 1'b1;
            #1;
            checks++;
            if (bus.mem_addr_valid !== 1'b1 || bus.agu_addr_ready !== 1'b1 ||
                bus.mem_addr !== addr || bus.mem_burst_len !== blen ||
                bus.mem_burst_size !== bsz ||
                bus.mem_last !== (b == nbeats - 1) ||
                bus.mem_id !== IW'(w) || bus.agu_cfg_valid !== 1'b0) begin
                errors++;
                $display("FAIL beat: a=%h len=%h sz=%h last=%b id=%0d cv=%b want %h %h %h %b %0d 0",
                         bus.mem_addr, bus.mem_burst_len, bus.mem_burst_size,
                         bus.mem_last, bus.mem_id, bus.agu_cfg_valid,
                         addr, blen, bsz, (b == nbeats - 1), w);
            end
            if (bus.mem_addr_valid && bus.agu_addr_ready) seen++;
            @(negedge clk_i);
        end
        idle_inputs();
        checks++;
        if (seen != nbeats) begin
            errors++;
            $display("FAIL beat_count: got=%0d want=%0d", seen, nbeats);
        end
        bus.agu_done = 1'b1;
        #1;
        checks++;
        if (req_done_o !== N'(1 << w) || bus.mem_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL done: done=%b mv=%b want %b 0",
                     req_done_o, bus.mem_addr_valid, N'(1 << w));
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (req_done_o !== '0 || busy_o !== 1'b1 ||
            bus.agu_cfg_valid !== 1'b0 || req_ready_o !== '0) begin
            errors++;
            $display("FAIL release: done=%b busy=%b cv=%b ready=%b want 0 1 0 0",
                     req_done_o, busy_o, bus.agu_cfg_valid, req_ready_o);
        end
        @(negedge clk_i);
        bus.agu_done = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || active_id_o !== IW'(w) || req_done_o !== '0) begin
            errors++;
            $display("FAIL idle_after: busy=%b id=%0d done=%b want 0 %0d 0",
                     busy_o, active_id_o, req_done_o, w);
        end
    endtask

    task automatic do_reset();
        rst_ni      = 1'b0;
        req_valid_i = '0;
        idle_inputs();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        rr_ptr = 0;
    endtask

    task automatic test_reset();
        req_cfg_i = '0;
        do_reset();
        #1;
        checks++;
        if ({req_ready_o, req_done_o, bus.agu_cfg_valid, bus.agu_start,
             bus.agu_addr_ready, bus.mem_addr_valid, busy_o, active_id_o,
             bus.mem_id} !== '0 || bus.agu_cfg !== '0 || bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b cv=%b busy=%b cfg=%h want all 0",
                     req_ready_o, req_done_o, bus.agu_cfg_valid, busy_o,
                     bus.agu_cfg);
        end
    endtask

    task automatic test_single_job();
        agu_cfg_t c;
        c.base      = 32'h1000;
        c.stride    = 32'd4;
        c.count     = 16'd64;
        c.elem_size = 32'd4;
        c.pattern   = LINEAR;
        req_cfg_i[0] = c;
        req_valid_i  = 3'b001;
        do_job(4, 0, 0);
    endtask

    task automatic test_rr_order();
        do_reset();
        for (int i = 0; i < N; i++) req_cfg_i[i] = rand_cfg(1'b0);
        req_valid_i = 3'b111;
        for (int i = 0; i < N; i++) do_job(2, 0, 0);
        req_valid_i = 3'b101;
        do_job(1, 1, 0);
        do_job(1, 0, 1);
    endtask

    task automatic test_backpressure();
        req_cfg_i[1] = rand_cfg(1'b0);
        req_valid_i  = 3'b010;
        do_job(5, 0, 10);
    endtask

    task automatic test_zero_count();
        req_cfg_i[1] = rand_cfg(1'b1);
        req_valid_i  = 3'b010;
        do_job(1, 0, 0);
    endtask

    task automatic test_cfg_stall();
        req_cfg_i[2] = rand_cfg(1'b0);
        req_valid_i  = 3'b100;
        do_job(2, 5, 0);
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        for (int it = 0; it < 15; it++) begin
            mask = N'($urandom_range(1, 7));
            for (int i = 0; i < N; i++)
                req_cfg_i[i] = rand_cfg($urandom_range(0, 4) == 0);
            req_valid_i = mask;
            while (req_valid_i != '0)
                do_job($urandom_range(1, 4), $urandom_range(0, 3),
                       $urandom_range(0, 3));
        end
    endtask

    task automatic test_reset_mid_run();
        req_cfg_i[2] = rand_cfg(1'b0);
        req_valid_i  = 3'b100;
        @(negedge clk_i);
        req_valid_i = '0;
        bus.agu_cfg_ready = 1'b1;
        @(negedge clk_i);
        bus.agu_cfg_ready  = 1'b0;
        bus.agu_addr_valid = 1'b1;
        bus.agu_addr       = req_cfg_i[2].base;
        bus.mem_addr_ready = 1'b1;
        #1;
        checks++;
        if (bus.mem_addr_valid !== 1'b1 || bus.mem_id !== IW'(2)) begin
            errors++;
            $display("FAIL pre_reset_run: mv=%b id=%0d want 1 2",
                     bus.mem_addr_valid, bus.mem_id);
        end
        rst_ni = 1'b0;
        bus.agu_done = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, req_done_o, bus.agu_cfg_valid, bus.agu_start,
             bus.agu_addr_ready, bus.mem_addr_valid, busy_o, active_id_o,
             bus.mem_id} !== '0 || bus.agu_cfg !== '0 || bus.mem_addr !== '0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b done=%b mv=%b busy=%b id=%0d want all 0",
                     req_ready_o, req_done_o, bus.mem_addr_valid, busy_o,
                     active_id_o);
        end
        @(negedge clk_i);
        #1;
        checks++;
        if (req_done_o !== '0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: done=%b busy=%b want 0 0",
                     req_done_o, busy_o);
        end
        idle_inputs();
        rst_ni = 1'b1;
        rr_ptr = 0;
        @(negedge clk_i);
        for (int i = 0; i < N; i++) req_cfg_i[i] = rand_cfg(1'b0);
        req_valid_i = 3'b101;
        do_job(2, 0, 0);
        do_job(1, 0, 0);
    endtask

    initial begin
        req_valid_i = '0;
        idle_inputs();
        test_reset();
        test_single_job();
        test_rr_order();
        test_backpressure();
        test_zero_count();
        test_cfg_stall();
        test_random();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: sim time exceeded, want completion");
        $fatal(1);
    end

endmodule
